mac_stream_drv: RTL and testbench

Host-side sequencer driving the input stream of the NxN MAC systolic array and collecting its result stream. Takes load commands and operand bytes over valid/ready, emits the array's `data_v/data_mode/data_rst_addr/data` beats, and buffers returned result beats in a FIFO for the host. It sits between the host transport (UART/JTAG bridge) and the MAC array top.

---
 rtl/mac_stream_if.sv | 34 +++
 rtl/mac_stream_drv.sv | 127 ++++++++++++
 tb/tb_mac_stream_drv.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_stream_if.sv
// mac_stream_if: host/array stream bundle for mac_stream_drv
// slave : the sequencer (consumes commands/operands/results, drives beats and host results)
// master: the host/test side driving commands, operands and array results
interface mac_stream_if #(parameter int W = 8);
  logic         ena;
  logic         cmd_v_i;
  logic         cmd_ready_o;
  logic         cmd_mode_i;
  logic         in_v_i;
  logic         in_ready_o;
  logic [W-1:0] in_data_i;
  logic         data_v_o;
  logic         data_mode_o;
  logic         data_rst_addr_o;
  logic [W-1:0] data_o;
  logic         result_v_i;
  logic [W-1:0] result_i;
  logic         res_v_o;
  logic         res_ready_i;
  logic [W-1:0] res_o;
  logic         busy_o;
  logic         timeout_o;
  logic         ovf_o;
  modport slave (
    input  ena, cmd_v_i, cmd_mode_i, in_v_i, in_data_i, result_v_i, result_i, res_ready_i,
    output cmd_ready_o, in_ready_o, data_v_o, data_mode_o, data_rst_addr_o, data_o,
           res_v_o, res_o, busy_o, timeout_o, ovf_o
  );
  modport master (
    output ena, cmd_v_i, cmd_mode_i, in_v_i, in_data_i, result_v_i, result_i, res_ready_i,
    input  cmd_ready_o, in_ready_o, data_v_o, data_mode_o, data_rst_addr_o, data_o,
           res_v_o, res_o, busy_o, timeout_o, ovf_o
  );
endinterface

// File: rtl/mac_stream_drv.sv
// mac_stream_drv: host-side sequencer feeding the NxN MAC array and buffering its results
// clk, rst_n (async, active-low); bus (mac_stream_if.slave):
//   cmd_v_i/cmd_ready_o/cmd_mode_i  load command (1 = weights, 0 = vector)
//   in_v_i/in_ready_o/in_data_i     operand bytes
//   data_v_o/data_mode_o/data_rst_addr_o/data_o  registered beats to the array
//   result_v_i/result_i             array results, captured into the FIFO
//   res_v_o/res_ready_i/res_o       FIFO head to the host
//   busy_o, timeout_o (sticky), ovf_o (sticky)
module mac_stream_drv #(
  parameter int W          = 8,
  parameter int N          = 2,
  parameter int TIMEOUT    = 64,
  parameter int FIFO_DEPTH = 2 * N
) (
  input logic       clk,
  input logic       rst_n,
  mac_stream_if.slave bus
);
  localparam int CW = $clog2(N * N + 1);
  localparam int RW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, WLOAD, DLOAD, WAIT} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] rcnt, rcnt_n, rcnt_inc;
  logic [TW-1:0] timer, timer_n;
  logic          to_set, in_hs, cmd_hs;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, free;
  logic          full, empty, push, pop;
  assign empty    = occ == '0;
  assign full     = occ == OW'(FIFO_DEPTH);
  assign free     = OW'(FIFO_DEPTH) - occ;
  assign pop      = ~empty & bus.res_ready_i;
  // a full FIFO still accepts a result when the head leaves in the same cycle
  assign push     = bus.result_v_i & (~full | pop);
  assign bus.res_v_o = ~empty;
  assign bus.res_o   = empty ? '0 : mem[rd_ptr];
  // a vector load is only accepted when its N results are guaranteed room
  assign bus.cmd_ready_o = bus.ena & (state == IDLE) & (bus.cmd_mode_i | (free >= OW'(N)));
  assign bus.in_ready_o  = bus.ena & ((state == WLOAD) | (state == DLOAD));
  assign cmd_hs   = bus.cmd_v_i & bus.cmd_ready_o;
  assign in_hs    = bus.in_v_i & bus.in_ready_o;
  assign rcnt_inc = rcnt + RW'(bus.result_v_i);
  assign bus.busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    timer_n = timer;
    to_set  = 1'b0;
    if (bus.ena) begin
      case (state)
        IDLE: if (cmd_hs) begin
          state_n = bus.cmd_mode_i ? WLOAD : DLOAD;
          cnt_n   = '0;
        end
        WLOAD: if (in_hs) begin
          cnt_n   = cnt + 1'b1;
          state_n = (cnt == CW'(N * N - 1)) ? IDLE : WLOAD;
        end
        DLOAD: if (in_hs) begin
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state_n = WAIT;
            rcnt_n  = '0;
            timer_n = '0;
          end
        end
        WAIT: begin
          rcnt_n  = rcnt_inc;
          timer_n = timer + 1'b1;
          // a result completing the set wins over an expiring timer
          if (rcnt_inc == RW'(N)) state_n = IDLE;
          else if (timer == TW'(TIMEOUT - 1)) begin
            state_n = IDLE;
            to_set  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rcnt  <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rcnt  <= rcnt_n;
      timer <= timer_n;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.data_v_o        <= 1'b0;
      bus.data_mode_o     <= 1'b0;
      bus.data_rst_addr_o <= 1'b0;
      bus.data_o          <= '0;
      bus.timeout_o       <= 1'b0;
      bus.ovf_o           <= 1'b0;
    end else begin
      bus.data_v_o        <= in_hs;
      bus.data_rst_addr_o <= in_hs & (cnt == '0);
      bus.data_mode_o     <= in_hs ? (state == WLOAD) : bus.data_mode_o;
      bus.data_o          <= in_hs ? bus.in_data_i : bus.data_o;
      bus.timeout_o       <= bus.timeout_o | to_set;
      bus.ovf_o           <= bus.ovf_o | (bus.result_v_i & full & ~pop);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= push ? ((wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1) : wr_ptr;
      rd_ptr <= pop ? ((rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1) : rd_ptr;
      occ    <= occ + OW'(push) - OW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.result_i;
endmodule

// File: tb/tb_mac_stream_drv.sv
// tb_mac_stream_drv: directed table-driven checks of mac_stream_drv (W=8, N=2, TIMEOUT=64)
module tb_mac_stream_drv;
  localparam int TO = 64;
  typedef struct {
    logic [7:0] din;
    logic       mode;
    logic       rst;
  } vec_t;
  logic clk, rst_n;
  int   tests = 0, fails = 0;
  vec_t tab [15];
  mac_stream_if #(.W(8)) bus ();
  mac_stream_drv #(.W(8), .N(2), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic load(input int first, input int n);
    bus.cmd_v_i    = 1'b1;
    bus.cmd_mode_i = tab[first].mode;
    #1 chk("cmd_ready", bus.cmd_ready_o, 1);
    tick();
    bus.cmd_v_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.in_v_i    = 1'b1;
      bus.in_data_i = tab[first + i].din;
      tick();
      chk("beat_v", bus.data_v_o, 1);
      chk("beat_data", bus.data_o, tab[first + i].din);
      chk("beat_mode", bus.data_mode_o, tab[first + i].mode);
      chk("beat_rst_addr", bus.data_rst_addr_o, tab[first + i].rst);
    end
    bus.in_v_i = 1'b0;
  endtask
  task automatic res(input logic [7:0] v);
    bus.result_v_i = 1'b1;
    bus.result_i   = v;
    tick();
    bus.result_v_i = 1'b0;
  endtask
  initial begin
    tab[0]  = '{8'h01, 1'b1, 1'b1};
    tab[1]  = '{8'h02, 1'b1, 1'b0};
    tab[2]  = '{8'h03, 1'b1, 1'b0};
    tab[3]  = '{8'h04, 1'b1, 1'b0};
    tab[4]  = '{8'h05, 1'b0, 1'b1};
    tab[5]  = '{8'h06, 1'b0, 1'b0};
    tab[6]  = '{8'h07, 1'b0, 1'b1};
    tab[7]  = '{8'h08, 1'b0, 1'b0};
    tab[8]  = '{8'h09, 1'b0, 1'b1};
    tab[9]  = '{8'h0A, 1'b0, 1'b0};
    tab[10] = '{8'h0B, 1'b0, 1'b1};
    tab[11] = '{8'h0C, 1'b0, 1'b0};
    tab[12] = '{8'h55, 1'b0, 1'b1};
    tab[13] = '{8'h66, 1'b0, 1'b1};
    tab[14] = '{8'h77, 1'b0, 1'b0};
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.cmd_v_i = 1'b0;
    bus.cmd_mode_i = 1'b0;
    bus.in_v_i = 1'b0;
    bus.in_data_i = '0;
    bus.result_v_i = 1'b0;
    bus.result_i = '0;
    bus.res_ready_i = 1'b0;
    #1;
    chk("rst_data_v", bus.data_v_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_res_v", bus.res_v_o, 0);
    chk("rst_res", bus.res_o, 0);
    chk("rst_flags", {bus.timeout_o, bus.ovf_o}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    // weight load, back-to-back
    load(0, 4);
    chk("wload_busy", bus.busy_o, 0);
    chk("wload_in_ready", bus.in_ready_o, 0);
    tick();
    chk("wload_gap", bus.data_v_o, 0);
    // vector load with two results
    load(4, 2);
    chk("dload_wait_busy", bus.busy_o, 1);
    chk("wait_in_ready", bus.in_ready_o, 0);
    res(8'h11);
    chk("wait_one_res", bus.busy_o, 1);
    res(8'h22);
    chk("wait_done", bus.busy_o, 0);
    chk("res_v1", bus.res_v_o, 1);
    chk("res_head1", bus.res_o, 8'h11);
    bus.res_ready_i = 1'b1;
    tick();
    chk("res_head2", bus.res_o, 8'h22);
    tick();
    bus.res_ready_i = 1'b0;
    chk("res_empty", bus.res_v_o, 0);
    chk("res_empty_val", bus.res_o, 0);
    // timeout with a single result
    load(6, 2);
    res(8'h33);
    repeat (TO - 2) tick();
    chk("to_before", bus.timeout_o, 0);
    chk("to_before_busy", bus.busy_o, 1);
    tick();
    chk("to_after", bus.timeout_o, 1);
    chk("to_idle", bus.busy_o, 0);
    chk("to_res", bus.res_o, 8'h33);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    chk("to_drained", bus.res_v_o, 0);
    // backpressure and overflow
    load(8, 2);
    res(8'h41);
    res(8'h42);
    load(10, 2);
    res(8'h43);
    res(8'h44);
    bus.cmd_v_i = 1'b1;
    bus.cmd_mode_i = 1'b0;
    #1 chk("full_cmd_refused", bus.cmd_ready_o, 0);
    bus.cmd_mode_i = 1'b1;
    #1 chk("full_wcmd_ok", bus.cmd_ready_o, 1);
    bus.cmd_mode_i = 1'b0;
    bus.result_v_i = 1'b1;
    bus.result_i = 8'hEE;
    tick();
    bus.result_v_i = 1'b0;
    chk("ovf_set", bus.ovf_o, 1);
    chk("ovf_busy", bus.busy_o, 0);
    chk("ovf_head", bus.res_o, 8'h41);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    #1 chk("one_pop_refused", bus.cmd_ready_o, 0);
    bus.res_ready_i = 1'b1;
    tick();
    bus.res_ready_i = 1'b0;
    #1 chk("two_pop_ready", bus.cmd_ready_o, 1);
    bus.cmd_v_i = 1'b0;
    chk("order3", bus.res_o, 8'h43);
    bus.res_ready_i = 1'b1;
    tick();
    chk("order4", bus.res_o, 8'h44);
    tick();
    bus.res_ready_i = 1'b0;
    chk("ovf_drained", bus.res_v_o, 0);
    // enable stall mid weight load
    bus.cmd_v_i = 1'b1;
    bus.cmd_mode_i = 1'b1;
    tick();
    bus.cmd_v_i = 1'b0;
    bus.in_v_i = 1'b1;
    bus.in_data_i = 8'hA1;
    tick();
    chk("ena_b1", {bus.data_v_o, bus.data_rst_addr_o, bus.data_o}, {2'b11, 8'hA1});
    bus.in_data_i = 8'hA2;
    tick();
    chk("ena_b2", {bus.data_v_o, bus.data_rst_addr_o, bus.data_o}, {2'b10, 8'hA2});
    bus.ena = 1'b0;
    bus.in_data_i = 8'hA3;
    #1 chk("ena_in_ready", bus.in_ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ena_stall", {bus.data_v_o, bus.busy_o}, 2'b01);
    end
    bus.ena = 1'b1;
    tick();
    chk("ena_b3", {bus.data_v_o, bus.data_rst_addr_o, bus.data_mode_o, bus.data_o}, {3'b101, 8'hA3});
    bus.in_data_i = 8'hA4;
    tick();
    bus.in_v_i = 1'b0;
    chk("ena_b4", {bus.data_v_o, bus.data_rst_addr_o, bus.data_mode_o, bus.data_o}, {3'b101, 8'hA4});
    chk("ena_done", bus.busy_o, 0);
    // async reset mid vector load
    load(12, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", {bus.data_v_o, bus.data_rst_addr_o, bus.data_mode_o, bus.data_o}, 0);
    chk("arst_busy", bus.busy_o, 0);
    chk("arst_flags", {bus.timeout_o, bus.ovf_o}, 0);
    chk("arst_res", {bus.res_v_o, bus.res_o}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    load(13, 2);
    chk("arst_reload_wait", bus.busy_o, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
